// File: rtl/cymometer_mc.sv
// ----------------------------------------------------------------------------
// cymometer_mc
//   Multi-channel equal-precision frequency meter. Every measured input is
//   synchronised and edge-detected in sys_clk. Enabled channels are visited
//   round-robin and share one gate engine and one 64-cycle restoring divider.
//   The gate opens and closes on edges of the measured signal, so the counts
//   always cover a whole number of input periods.
//
// Ports
//   sys_clk     reference clock, the only clock
//   sys_rst_n   synchronous active-low reset
//   en          run enable; dropping it aborts a measurement in progress
//   clk_fx      measured signals, asynchronous to sys_clk
//   ch_en       per-channel enable mask, sampled only in IDLE
//   data_fx     measured frequency in Hz (all ones on overflow)
//   data_ch     channel index belonging to data_fx
//   no_sig      result came from a timeout; data_fx is 0
//   data_valid  result available
//   data_ready  consumer accepts the result
//   busy        high in every state except IDLE
// ----------------------------------------------------------------------------
module cymometer_mc #(
    parameter int CLK_FS      = 50_000_000,
    parameter int CH_NUM      = 4,
    parameter int GATE_CYC    = 25_000_000,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int DATA_W      = 32,
    localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              en,
    input  logic [CH_NUM-1:0] clk_fx,
    input  logic [CH_NUM-1:0] ch_en,
    output logic [DATA_W-1:0] data_fx,
    output logic [CH_W-1:0]   data_ch,
    output logic              no_sig,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              busy
);

    localparam logic [63:0] FS64 = 64'(CLK_FS);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_GATE, S_CLOSE, S_DIV, S_OUT} state_t;

    state_t            state, state_nxt;
    logic [CH_NUM-1:0] fx_s1, fx_s2, fx_hist, rise;
    logic [CH_W-1:0]   cur_ch, nxt_ch;
    logic              rise_sel;
    logic [31:0]       cnt_fs, cnt_fx, gate_cnt, to_cnt;
    logic              to_hit;
    logic [63:0]       quo;
    logic [31:0]       rem, rem_nxt;
    logic [6:0]        div_cnt;
    logic [32:0]       trial, diff;
    logic              q_bit;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [DATA_W-1:0] sat_quo(input logic [63:0] q);
        if ((q >> DATA_W) != 64'd0)
            return '1;
        else
            return q[DATA_W-1:0];
    endfunction

    assign rise   = fx_s2 & ~fx_hist;
    assign to_hit = (to_cnt == 32'(TIMEOUT_CYC - 1));

    // Nearest enabled channel after cur_ch, wrapping; distance 0 means cur_ch+1.
    always_comb begin
        int d;
        int best_d;
        d      = 0;
        best_d = CH_NUM;
        nxt_ch = cur_ch;
        for (int i = 0; i < CH_NUM; i++) begin
            d = (i - int'(cur_ch) - 1 + 2 * CH_NUM) % CH_NUM;
            if (ch_en[i] && d < best_d) begin
                best_d = d;
                nxt_ch = CH_W'(i);
            end
        end
    end

    always_comb begin
        rise_sel = 1'b0;
        for (int i = 0; i < CH_NUM; i++)
            if (cur_ch == CH_W'(i)) rise_sel = rise[i];
    end

    // One restoring-division step: remainder never exceeds the divisor, so the
    // borrow bit of the 33-bit difference decides the quotient bit.
    assign trial = {rem, quo[63]};
    assign diff  = trial - {1'b0, cnt_fs};
    always_comb begin
        q_bit   = ~diff[32];
        rem_nxt = diff[32] ? trial[31:0] : diff[31:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (en && (ch_en != '0)) state_nxt = S_ARM;
            S_ARM:   if (!en)                          state_nxt = S_IDLE;
                     else if (rise_sel)                state_nxt = S_GATE;
                     else if (to_hit)                  state_nxt = S_OUT;
            S_GATE:  if (!en)                          state_nxt = S_IDLE;
                     else if (gate_cnt == 32'(GATE_CYC)) state_nxt = S_CLOSE;
            S_CLOSE: if (!en)                          state_nxt = S_IDLE;
                     else if (rise_sel)                state_nxt = S_DIV;
                     else if (to_hit)                  state_nxt = S_OUT;
            S_DIV:   if (!en)                          state_nxt = S_IDLE;
                     else if (div_cnt == 7'd63)        state_nxt = S_OUT;
            S_OUT:   if (data_ready)                   state_nxt = S_IDLE;
            default:                                   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    // Control and output registers.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            fx_s1      <= '0;
            fx_s2      <= '0;
            fx_hist    <= '0;
            cur_ch     <= CH_W'(CH_NUM - 1);
            data_fx    <= '0;
            data_ch    <= '0;
            no_sig     <= 1'b0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            fx_s1      <= clk_fx;
            fx_s2      <= fx_s1;
            fx_hist    <= fx_s2;
            data_valid <= (state_nxt == S_OUT);
            busy       <= (state_nxt != S_IDLE);
            if (state == S_IDLE && state_nxt == S_ARM)
                cur_ch <= nxt_ch;
            if (state != S_OUT && state_nxt == S_OUT) begin
                data_ch <= cur_ch;
                if (state == S_DIV) begin
                    data_fx <= sat_quo({quo[62:0], q_bit});
                    no_sig  <= 1'b0;
                end else begin
                    data_fx <= '0;
                    no_sig  <= 1'b1;
                end
            end
        end
    end

    // Counters and divider; always re-initialised before use, so no reset.
    always_ff @(posedge sys_clk) begin
        case (state)
            S_IDLE: begin
                cnt_fs   <= '0;
                cnt_fx   <= '0;
                gate_cnt <= '0;
                to_cnt   <= '0;
            end
            S_ARM: begin
                if (rise_sel) begin
                    cnt_fx   <= 32'd1;
                    cnt_fs   <= 32'd1;
                    gate_cnt <= 32'd1;
                end else begin
                    to_cnt <= to_cnt + 32'd1;
                end
            end
            S_GATE: begin
                cnt_fs   <= sat_inc(cnt_fs);
                gate_cnt <= gate_cnt + 32'd1;
                to_cnt   <= '0;
                if (rise_sel) cnt_fx <= sat_inc(cnt_fx);
            end
            S_CLOSE: begin
                // The closing edge belongs to the next period: count nothing.
                if (rise_sel) begin
                    quo     <= FS64 * {32'd0, cnt_fx};
                    rem     <= '0;
                    div_cnt <= '0;
                end else begin
                    cnt_fs <= sat_inc(cnt_fs);
                    to_cnt <= to_cnt + 32'd1;
                end
            end
            S_DIV: begin
                quo     <= {quo[62:0], q_bit};
                rem     <= rem_nxt;
                div_cnt <= div_cnt + 7'd1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cymometer_mc.sv
module tb_cymometer_mc;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        en = 1'b0;
    logic        data_ready = 1'b1;
    logic [3:0]  clk_fx = '0;
    logic [3:0]  ch_en = '0;
    logic [31:0] data_fx;
    logic [1:0]  data_ch;
    logic        no_sig, data_valid, busy;

    logic        en16 = 1'b0;
    logic [15:0] data_fx16;
    logic [0:0]  data_ch16;
    logic        no_sig16, data_valid16, busy16;

    int n_total = 0;
    int n_pass  = 0;
    int sat_seen = 0;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] fx;
        logic        ns;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    int   per [4] = '{50, 100, 0, 250};
    int   ph  [4] = '{0, 0, 0, 0};
    logic [3:0] man = '0;

    always #5 sys_clk = ~sys_clk;

    cymometer_mc #(
        .CLK_FS(50_000_000), .CH_NUM(4), .GATE_CYC(5000),
        .TIMEOUT_CYC(1000), .DATA_W(32)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en),
        .clk_fx(clk_fx), .ch_en(ch_en),
        .data_fx(data_fx), .data_ch(data_ch), .no_sig(no_sig),
        .data_valid(data_valid), .data_ready(data_ready), .busy(busy)
    );

    cymometer_mc #(
        .CLK_FS(50_000_000), .CH_NUM(1), .GATE_CYC(5000),
        .TIMEOUT_CYC(1000), .DATA_W(16)
    ) dut16 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en16),
        .clk_fx(clk_fx[0:0]), .ch_en(1'b1),
        .data_fx(data_fx16), .data_ch(data_ch16), .no_sig(no_sig16),
        .data_valid(data_valid16), .data_ready(1'b1), .busy(busy16)
    );

    // Square waves with an exact period in sys_clk cycles; period 0 = manual.
    always @(negedge sys_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (per[i] == 0) begin
                clk_fx[i] = man[i];
                ph[i] = 0;
            end else begin
                clk_fx[i] = (ph[i] < per[i] / 2);
                ph[i] = (ph[i] + 1 >= per[i]) ? 0 : ph[i] + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL %s: %0d results pending after %0d cycles, required 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    // Scoreboard monitor: every accepted result is matched against the queue.
    always @(negedge sys_clk) begin
        if (sys_rst_n === 1'b1 && data_valid === 1'b1 && data_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_result: got ch=%0d fx=%0d no_sig=%0d, required none",
                         data_ch, data_fx, no_sig);
            end else begin
                e = exp_q.pop_front();
                chk("result_ch", 64'(data_ch), 64'(e.ch));
                chk("result_fx", 64'(data_fx), 64'(e.fx));
                chk("result_no_sig", 64'(no_sig), 64'(e.ns));
            end
        end
    end

    // 16-bit instance: 1 MHz cannot be represented, every result saturates.
    always @(negedge sys_clk) begin
        if (sys_rst_n === 1'b1 && data_valid16 === 1'b1) begin
            sat_seen++;
            chk("sat_fx", 64'(data_fx16), 64'hFFFF);
            chk("sat_no_sig", 64'(no_sig16), 64'd0);
            chk("sat_ch", 64'(data_ch16), 64'd0);
        end
    end

    initial begin
        int n;

        // Reset state
        sys_rst_n = 1'b0;
        cyc(3);
        chk("rst_data_fx", 64'(data_fx), 64'd0);
        chk("rst_data_ch", 64'(data_ch), 64'd0);
        chk("rst_no_sig", 64'(no_sig), 64'd0);
        chk("rst_data_valid", 64'(data_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        sys_rst_n = 1'b1;
        en16 = 1'b1;
        cyc(2);

        // Round-robin over channels 0, 1, 3; channel 2 must never appear
        exp_q.push_back('{ch: 2'd0, fx: 32'd1_000_000, ns: 1'b0});
        exp_q.push_back('{ch: 2'd1, fx: 32'd500_000,   ns: 1'b0});
        exp_q.push_back('{ch: 2'd3, fx: 32'd200_000,   ns: 1'b0});
        exp_q.push_back('{ch: 2'd0, fx: 32'd1_000_000, ns: 1'b0});
        ch_en = 4'b1011;
        en = 1'b1;
        wait_empty("round_robin", 30000);
        en = 1'b0;
        cyc(2);

        // Dead input on channel 1: timeout from ARM
        per[1] = 0;
        man[1] = 1'b0;
        cyc(5);
        exp_q.push_back('{ch: 2'd1, fx: 32'd0, ns: 1'b1});
        ch_en = 4'b0010;
        en = 1'b1;
        n = 0;
        while (data_valid !== 1'b1 && n < 2000) begin
            cyc(1);
            n++;
        end
        chk("dead_latency_in_995_1010", 64'(n >= 995 && n <= 1010), 64'd1);
        wait_empty("dead_input", 10);
        en = 1'b0;
        cyc(2);

        // Back-pressure: result held while data_ready is low
        data_ready = 1'b0;
        exp_q.push_back('{ch: 2'd0, fx: 32'd1_000_000, ns: 1'b0});
        ch_en = 4'b0001;
        en = 1'b1;
        n = 0;
        while (data_valid !== 1'b1 && n < 8000) begin
            cyc(1);
            n++;
        end
        chk("bp_valid_seen", 64'(data_valid), 64'd1);
        cyc(500);
        chk("bp_valid_held", 64'(data_valid), 64'd1);
        chk("bp_busy", 64'(busy), 64'd1);
        chk("bp_fx_frozen", 64'(data_fx), 64'd1_000_000);
        chk("bp_ch_frozen", 64'(data_ch), 64'd0);
        data_ready = 1'b1;
        wait_empty("backpressure", 10);
        en = 1'b0;
        chk("bp_valid_drop", 64'(data_valid), 64'd0);
        chk("bp_idle", 64'(busy), 64'd0);
        cyc(2);

        // Abort inside GATE: idle next cycle, no result
        ch_en = 4'b0001;
        en = 1'b1;
        cyc(300);
        chk("abort_busy_before", 64'(busy), 64'd1);
        en = 1'b0;
        cyc(1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(data_valid), 64'd0);
        cyc(50);

        // Reset during DIV of a manually driven channel-1 measurement
        ch_en = 4'b0011;
        en = 1'b1;
        cyc(20);
        man[1] = 1'b1;
        cyc(10);
        man[1] = 1'b0;
        cyc(5100);
        man[1] = 1'b1;
        cyc(10);
        man[1] = 1'b0;
        cyc(20);
        sys_rst_n = 1'b0;
        cyc(1);
        chk("divrst_data_fx", 64'(data_fx), 64'd0);
        chk("divrst_data_ch", 64'(data_ch), 64'd0);
        chk("divrst_no_sig", 64'(no_sig), 64'd0);
        chk("divrst_data_valid", 64'(data_valid), 64'd0);
        chk("divrst_busy", 64'(busy), 64'd0);
        exp_q.push_back('{ch: 2'd0, fx: 32'd1_000_000, ns: 1'b0});
        sys_rst_n = 1'b1;
        wait_empty("after_reset", 8000);
        en = 1'b0;
        cyc(5);

        chk("sat_results_seen", 64'(sat_seen > 0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cymometer_mc.md
# cymometer_mc

Multi-channel, parametrised equal-precision frequency meter, and the next generation of the single-channel cymometer. It is fully synchronous to the reference clock: each measured input is synchronised and edge-detected in `sys_clk`, not used as a clock. Enabled channels are measured round-robin and share one gate engine and one sequential divider. Each result is returned over a valid/ready handshake for the display or host layer, together with its channel index and a no-signal flag.

## Interface
- `CLK_FS`, 50_000_000: reference clock frequency in Hz (numerator constant).
- `CH_NUM`, 4: number of measured inputs (1..16).
- `GATE_CYC`, 25_000_000: software gate length in `sys_clk` cycles.
- `TIMEOUT_CYC`, 50_000_000: maximum wait for a measured edge before declaring no signal.
- `DATA_W`, 32: result width (16..32).
- `sys_clk`  in  1  reference clock; the only clock.
- `sys_rst_n`  in  1  reset; synchronous, active-low.
- `en`  in  1  run enable.
- `clk_fx`  in  CH_NUM  measured signals, asynchronous to `sys_clk`.
- `ch_en`  in  CH_NUM  per-channel enable mask.
- `data_fx`  out  DATA_W  measured frequency in Hz.
- `data_ch`  out  CH_W = max(1, clog2(CH_NUM))  channel index of `data_fx`.
- `no_sig`  out  1  result came from a timeout; `data_fx` = 0.
- `data_valid`  out  1  result available.
- `data_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Input conditioning:** each `clk_fx` bit passes through a 2-FF synchroniser, then a history FF. `rise[i]` = synced & ~history. Supported range is fx < CLK_FS/4.
- **Counters:**
  - `cnt_fs` is 32 bits, saturating.
  - `cnt_fx` is 32 bits, saturating.
  - `gate_cnt` counts the soft gate.
  - `to_cnt` counts the timeout.
- **FSM states:** IDLE, ARM, GATE, CLOSE, DIV, OUT.
- **IDLE**
  - If `en` = 1 and `ch_en` ≠ 0, select the next enabled channel.
  - Search starts at current index+1 and wraps modulo CH_NUM. After reset the search starts at channel 0.
  - Clear all counters, then go to ARM.
- **ARM:** wait for `rise[sel]`.
  - On the first `rise[sel]`, open the real gate: `cnt_fx` = 1, `cnt_fs` = 1, `gate_cnt` = 1, then go to GATE.
  - If `to_cnt` reaches TIMEOUT_CYC first, set `no_sig` = 1, result = 0, go to OUT.
- **GATE**
  - Every cycle: `cnt_fs`++ and `gate_cnt`++.
  - On each `rise[sel]`: `cnt_fx`++.
  - When `gate_cnt` = GATE_CYC, go to CLOSE.
- **CLOSE**
  - Keep counting `cnt_fs`.
  - On the next `rise[sel]`, close the gate. That edge is counted in neither counter. Go to DIV.
  - If `to_cnt` (cleared on CLOSE entry) reaches TIMEOUT_CYC first, treat it as a timeout (`no_sig` = 1, result 0, go to OUT).
- **Gate property:** for a periodic input, `cnt_fs` = N·period and `cnt_fx` = N exactly.
- **DIV**
  - Restoring division, one quotient bit per cycle, exactly 64 cycles.
  - Numerator = CLK_FS × `cnt_fx`, 64-bit unsigned. Divisor = `cnt_fs`.
  - Quotient is truncated (floor).
  - If the quotient exceeds 2^DATA_W − 1, `data_fx` saturates to all ones.
- **OUT**
  - `data_valid` = 1. `data_fx`, `data_ch` and `no_sig` are stable.
  - On `data_valid & data_ready`, go to IDLE next cycle.
- **Enable handling**
  - `en` = 0 in ARM, GATE, CLOSE or DIV: abort to IDLE next cycle with no output.
  - OUT is never aborted.
- **Mask handling**
  - `ch_en` is sampled only in IDLE.
  - Mask = 0 keeps the block in IDLE.

## Timing
- **Reset:** `data_fx` = 0, `data_ch` = 0, `no_sig` = 0, `data_valid` = 0, `busy` = 0. FSM goes to IDLE, last channel index = CH_NUM−1 (so the first pick is channel 0). Reset wins over every state, including mid-DIV.
- **Edge latency:** 3 cycles from a pin transition to `rise`. It is constant, so it cancels out of the measurement.
- **Result latency:** the gate close edge is followed by 64 DIV cycles, then `data_valid` rises on the next cycle. Timeout paths skip DIV, with 1 cycle to OUT.
- **Outputs:** all registered. `data_valid` falls the cycle after the handshake.
- **Back-pressure:** `data_ready` may be high before `data_valid`, giving a 1-cycle OUT. While `data_ready` = 0, no new measurement starts.
- **Scan period** per channel ≈ GATE_CYC + one fx period + 3 edge latency + 64 + 2 cycles.

## Test plan
- **Single channel:** CLK_FS = 50M, GATE_CYC = 5000, CH_NUM = 1, fx period 50 cycles (1 MHz), `data_ready` = 1 → `data_fx` = 1_000_000, `no_sig` = 0, `data_valid` = 1 for 1 cycle.
- **Round-robin:** CH_NUM = 4, `ch_en` = 4'b1011, periods 50/100/–/250 on channels 0/1/3 → `data_ch` sequence 0, 1, 3, 0 with 1_000_000, 500_000, 200_000. Channel 2 never reported.
- **Dead input:** channel 1 held low, TIMEOUT_CYC = 1000 → `data_ch` = 1, `data_fx` = 0, `no_sig` = 1, about 1000 cycles after ARM entry. A signal stopping in CLOSE gives the same response.
- **Back-pressure:** `data_ready` = 0 for 500 cycles after `data_valid` → outputs frozen, `busy` = 1, no `clk_fx` activity is counted. Releasing `data_ready` gives one handshake, then IDLE.
- **Saturation:** DATA_W = 16, fx = 1 MHz → `data_fx` = 16'hFFFF.
- **Abort and reset:** `en` dropped in GATE → IDLE next cycle, no `data_valid`. `sys_rst_n` = 0 for 1 cycle during DIV → all outputs 0 next cycle. The next measurement starts at channel 0.
